elastic_dff_pipe: RTL

- Parametrised, flow-controlled successor to the single-bit DFF_X1/DFFR_X1 cells: a WIDTH-bit, DEPTH-stage register pipeline with valid/ready handshake.
- Each stage is a two-entry skid buffer, so every ready is registered and throughput is one word per cycle.
- The resizer uses it as a retiming/repeater target on long buffered nets, and in tests that exercise register insertion.

---
 rtl/elastic_dff_pipe.sv | 120 ++++++++++++
 1 files changed

// File: rtl/elastic_dff_pipe.sv
// elastic_dff_pipe (rev 1.0): WIDTH-bit, DEPTH-stage valid/ready pipeline built from two-entry skid stages.
// Optional macro PIPE_PARITY_EN carries an even-parity bit per word and raises a sticky par_err.
`default_nettype none

module elastic_dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(2*DEPTH+1)
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             par_err
);

`ifdef PIPE_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif

  logic [DEPTH-1:0]          mv, sv;
  logic [DEPTH-1:0][EW-1:0]  md, sd;
  logic [DEPTH-1:0]          up_valid, down_ready, push, pop;
  logic [DEPTH-1:0][EW-1:0]  up_data;
  logic [EW-1:0]             in_word;
  logic                      in_fire, out_fire;

`ifdef PIPE_PARITY_EN
  assign in_word = {^in_data, in_data};
`else
  assign in_word = in_data;
`endif

  // Stage k is fed by stage k-1's main register and backpressured by stage k+1's skid.
  always_comb begin
    up_valid   = '0;
    up_data    = '0;
    down_ready = '0;
    up_valid[0]         = in_valid;
    up_data[0]          = in_word;
    down_ready[DEPTH-1] = out_ready;
    for (int k = 1; k < DEPTH; k++) begin
      up_valid[k] = mv[k-1];
      up_data[k]  = md[k-1];
    end
    for (int k = 0; k < DEPTH-1; k++) begin
      down_ready[k] = ~sv[k+1];
    end
    push = up_valid & ~sv;
    pop  = mv & down_ready;
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      mv <= '0;
      sv <= '0;
      md <= '0;
      sd <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (sv[k]) begin
          if (pop[k]) begin
            md[k] <= sd[k];
            sv[k] <= 1'b0;
          end
        end else if (mv[k]) begin
          if (push[k] && !pop[k]) begin
            sv[k] <= 1'b1;
            sd[k] <= up_data[k];
          end else if (pop[k] && !push[k]) begin
            mv[k] <= 1'b0;
          end else if (push[k] && pop[k]) begin
            md[k] <= up_data[k];
          end
        end else if (push[k]) begin
          mv[k] <= 1'b1;
          md[k] <= up_data[k];
        end
      end
    end
  end

  assign in_ready  = ~sv[0];
  assign out_valid = mv[DEPTH-1];
  assign out_data  = md[DEPTH-1][WIDTH-1:0];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge CK) begin
    if (!RN) begin
      count <= '0;
    end else if (in_fire && !out_fire) begin
      count <= count + CNT_W'(1);
    end else if (out_fire && !in_fire) begin
      count <= count - CNT_W'(1);
    end
  end

`ifdef PIPE_PARITY_EN
  always_ff @(posedge CK) begin
    if (!RN) begin
      par_err <= 1'b0;
    end else if (out_fire && ((^md[DEPTH-1][WIDTH-1:0]) != md[DEPTH-1][WIDTH])) begin
      par_err <= 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

`default_nettype wire
